// File: rtl/pipelined_comparison_unit_pkg.sv
// Shared sizes, compare opcodes and the request record carried through the comparison pipeline.
package pipelined_comparison_unit_pkg;

    localparam int DATA_W    = 32;
    localparam int LANES     = 4;
    localparam int NUM_FLAGS = 8;

    // One extra index bit so callers can name an out-of-range flag, which the unit ignores.
    function automatic int fidx_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int FIDX_W = fidx_width(NUM_FLAGS);
    localparam int FSEL_W = FIDX_W - 1;

    typedef enum logic [2:0] {
        OP_GT   = 3'd0,
        OP_LT   = 3'd1,
        OP_EQ   = 3'd2,
        OP_NEQ  = 3'd3,
        OP_GTE  = 3'd4,
        OP_LTE  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } compare_op_t;

    typedef struct packed {
        logic [LANES*DATA_W-1:0] a;
        logic [LANES*DATA_W-1:0] b;
        compare_op_t             op;
        logic                    is_signed;
        logic [LANES-1:0]        lane_mask;
        logic                    cond_en;
        logic                    cond_negate;
        logic [FIDX_W-1:0]       cond_flag;
        logic                    set_en;
        logic                    set_negate;
        logic [FIDX_W-1:0]       set_flag;
    } cmp_req_t;

endpackage

// File: rtl/pipelined_comparison_unit_if.sv
// Request/result handshake, external flag-write port and flag file view of the comparison unit.
interface pipelined_comparison_unit_if;
    import pipelined_comparison_unit_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*DATA_W-1:0]  in_a;
    logic [LANES*DATA_W-1:0]  in_b;
    compare_op_t              in_op;
    logic                     in_signed;
    logic [LANES-1:0]         in_lane_mask;
    logic                     in_cond_en;
    logic                     in_cond_negate;
    logic [FIDX_W-1:0]        in_cond_flag;
    logic                     in_set_en;
    logic                     in_set_negate;
    logic [FIDX_W-1:0]        in_set_flag;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES-1:0]         out_result;
    logic [LANES-1:0]         out_exec;
    logic                     ext_wr_en;
    logic [LANES-1:0]         ext_wr_lanes;
    logic [FIDX_W-1:0]        ext_wr_flag;
    logic                     ext_wr_value;
    logic [LANES*NUM_FLAGS-1:0] flags;

    modport master (
        output in_valid, in_a, in_b, in_op, in_signed, in_lane_mask,
               in_cond_en, in_cond_negate, in_cond_flag,
               in_set_en, in_set_negate, in_set_flag,
               out_ready, ext_wr_en, ext_wr_lanes, ext_wr_flag, ext_wr_value,
        input  in_ready, out_valid, out_result, out_exec, flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_signed, in_lane_mask,
               in_cond_en, in_cond_negate, in_cond_flag,
               in_set_en, in_set_negate, in_set_flag,
               out_ready, ext_wr_en, ext_wr_lanes, ext_wr_flag, ext_wr_value,
        output in_ready, out_valid, out_result, out_exec, flags
    );

endinterface

// File: rtl/pipelined_comparison_unit_lane_comparator.sv
// Combinational single-lane compare of a against b; reserved opcodes yield 0.
module pipelined_comparison_unit_lane_comparator
    import pipelined_comparison_unit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  compare_op_t       op,
    input  logic              is_signed,
    output logic              raw
);

    logic gt;
    logic eq;

    always_comb begin
        eq  = (a == b);
        gt  = is_signed ? ($signed(a) > $signed(b)) : (a > b);
        raw = 1'b0;
        case (op)
            OP_GT:   raw = gt;
            OP_LT:   raw = !gt && !eq;
            OP_EQ:   raw = eq;
            OP_NEQ:  raw = !eq;
            OP_GTE:  raw = gt || eq;
            OP_LTE:  raw = !gt;
            default: raw = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipelined_comparison_unit.sv
// Two-stage multi-lane comparator with per-lane flag file: accept at edge k, result and flag commit at edge k+1.
// Result register holds until out_ready; a stalled request in S1 re-reads the flags every cycle.
module pipelined_comparison_unit
    import pipelined_comparison_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    pipelined_comparison_unit_if.slave  bus
);

    localparam logic [FIDX_W-1:0] FLAG_LIMIT = FIDX_W'(NUM_FLAGS);

    cmp_req_t                          in_req;
    cmp_req_t                          s1_req_d, s1_req_q;
    logic                              s1_valid_d, s1_valid_q;
    logic                              out_valid_d, out_valid_q;
    logic [LANES-1:0]                  out_result_d, out_result_q;
    logic [LANES-1:0]                  out_exec_d, out_exec_q;
    logic [LANES-1:0][NUM_FLAGS-1:0]   flags_d, flags_q;

    logic             s2_load;
    logic             accept;
    logic             cond_in_range;
    logic             set_in_range;
    logic             ext_in_range;
    logic [LANES-1:0] raw;
    logic [LANES-1:0] exec;
    logic [LANES-1:0] res;

    assign s2_load      = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !rst && (!s1_valid_q || s2_load);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_exec   = out_exec_q;
    assign bus.flags      = flags_q;

    always_comb begin
        in_req             = '0;
        in_req.a           = bus.in_a;
        in_req.b           = bus.in_b;
        in_req.op          = bus.in_op;
        in_req.is_signed   = bus.in_signed;
        in_req.lane_mask   = bus.in_lane_mask;
        in_req.cond_en     = bus.in_cond_en;
        in_req.cond_negate = bus.in_cond_negate;
        in_req.cond_flag   = bus.in_cond_flag;
        in_req.set_en      = bus.in_set_en;
        in_req.set_negate  = bus.in_set_negate;
        in_req.set_flag    = bus.in_set_flag;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pipelined_comparison_unit_lane_comparator u_cmp (
            .a         (s1_req_q.a[l*DATA_W +: DATA_W]),
            .b         (s1_req_q.b[l*DATA_W +: DATA_W]),
            .op        (s1_req_q.op),
            .is_signed (s1_req_q.is_signed),
            .raw       (raw[l])
        );
    end

    // S2 evaluation reads committed flags, so a flag written by the previous op is already visible.
    always_comb begin
        cond_in_range = (s1_req_q.cond_flag < FLAG_LIMIT);
        set_in_range  = (s1_req_q.set_flag < FLAG_LIMIT);
        ext_in_range  = (bus.ext_wr_flag < FLAG_LIMIT);
        exec          = '0;
        res           = '0;
        for (int l = 0; l < LANES; l++) begin
            exec[l] = s1_req_q.lane_mask[l] &&
                      (!s1_req_q.cond_en ||
                       (cond_in_range &&
                        (flags_q[l][s1_req_q.cond_flag[FSEL_W-1:0]] ^ s1_req_q.cond_negate)));
            res[l]  = exec[l] && (raw[l] ^ s1_req_q.set_negate);
        end
    end

    always_comb begin
        s1_req_d     = s1_req_q;
        s1_valid_d   = s1_valid_q && !s2_load;
        out_valid_d  = out_valid_q && !bus.out_ready;
        out_result_d = out_result_q;
        out_exec_d   = out_exec_q;
        flags_d      = flags_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_req_d   = in_req;
        end

        if (s2_load) begin
            out_valid_d  = 1'b1;
            out_result_d = res;
            out_exec_d   = exec;
        end

        // External write first so a pipeline write to the same flag overrides it.
        if (bus.ext_wr_en && ext_in_range) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.ext_wr_lanes[l]) begin
                    flags_d[l][bus.ext_wr_flag[FSEL_W-1:0]] = bus.ext_wr_value;
                end
            end
        end

        if (s2_load && s1_req_q.set_en && set_in_range) begin
            for (int l = 0; l < LANES; l++) begin
                if (exec[l]) begin
                    flags_d[l][s1_req_q.set_flag[FSEL_W-1:0]] = raw[l] ^ s1_req_q.set_negate;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_req_q     <= '0;
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_exec_q   <= '0;
            flags_q      <= '0;
        end else begin
            s1_req_q     <= s1_req_d;
            s1_valid_q   <= s1_valid_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_exec_q   <= out_exec_d;
            flags_q      <= flags_d;
        end
    end

endmodule
